// File: rtl/mux_2x1_arbiter_if.sv
// Handshake bundle between two requesters, the shared 2:1 mux arbiter and its
// downstream consumer.
interface mux_2x1_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic             sel;
    logic             busy;

    // Environment side: drives requests and downstream ready.
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, sel, busy
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, sel, busy
    );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 datapath mux between requesters A and B,
// feeding a one-deep registered output stage. Bursts are bounded by MAX_BURST.
module mux_2x1_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_2x1_arbiter_if.slave    bus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_gnt_q, last_gnt_d;   // 0 = A, 1 = B
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_src_q;

    logic             stage_free;
    logic             sel;
    logic             a_acc;
    logic             b_acc;
    logic [WIDTH-1:0] mux_data;

    assign stage_free = ~out_valid_q | bus.out_ready;
    assign sel        = (state_q == GNT_B);

    // Readies come only from our own state and the output stage, never the peer's valid.
    assign bus.a_ready = ~rst & (state_q == GNT_A) & stage_free;
    assign bus.b_ready = ~rst & (state_q == GNT_B) & stage_free;

    assign a_acc    = bus.a_valid & bus.a_ready;
    assign b_acc    = bus.b_valid & bus.b_ready;
    assign mux_data = sel ? bus.b_data : bus.a_data;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (bus.a_valid && bus.b_valid) begin
                    state_d = last_gnt_q ? GNT_A : GNT_B;
                end else if (bus.a_valid) begin
                    state_d = GNT_A;
                end else if (bus.b_valid) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (!bus.a_valid) begin
                    state_d    = bus.b_valid ? GNT_B : IDLE;
                    cnt_d      = '0;
                    last_gnt_d = 1'b0;
                end else if (a_acc) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (bus.b_valid) begin
                            state_d    = GNT_B;
                            last_gnt_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GNT_B: begin
                if (!bus.b_valid) begin
                    state_d    = bus.a_valid ? GNT_A : IDLE;
                    cnt_d      = '0;
                    last_gnt_d = 1'b1;
                end else if (b_acc) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (bus.a_valid) begin
                            state_d    = GNT_A;
                            last_gnt_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_gnt_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            // Accept implies stage_free, so load and unload can share a cycle.
            if (a_acc || b_acc) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_data;
                out_src_q   <= sel;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.sel       = sel;
    assign bus.busy      = (state_q != IDLE);
endmodule
